mux_scanner: RTL and testbench

MUX_SCANNER -- requirements
Module: mux_scanner

---
 rtl/mux_scanner_if.sv | 29 ++
 rtl/mux_scanner.sv | 79 +++++++
 tb/tb_mux_scanner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux_scanner_if.sv
// Channel scanner bus: channel data, mode and dwell controls in,
// selected data, channel index and status pulses out.
interface mux_scanner_if #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 1,
  parameter int DWELL_W = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic                  ena;
  logic [N_CH*WIDTH-1:0] data_in;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [DWELL_W-1:0]    dwell;
  logic [WIDTH-1:0]      data_out;
  logic [SEL_W-1:0]      ch_out;
  logic                  ch_step;
  logic                  sel_err;

  modport master (
    output ena, data_in, mode, sel, dwell,
    input  data_out, ch_out, ch_step, sel_err
  );

  modport slave (
    input  ena, data_in, mode, sel, dwell,
    output data_out, ch_out, ch_step, sel_err
  );
endinterface

// File: rtl/mux_scanner.sv
// Registered N-channel mux with manual select or
// auto-scan that dwells dwell+1 cycles per channel.
module mux_scanner #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 1,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scanner_if.slave  bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam logic [SEL_W:0]   NCH_V = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0]   cur_ch;
  logic [SEL_W-1:0]   ch_nxt;
  logic [DWELL_W-1:0] count;
  logic [DWELL_W-1:0] cnt_nxt;
  logic               step_nxt;
  logic               err_nxt;
  logic [WIDTH-1:0]   slice;
  logic [WIDTH-1:0]   data_q;
  logic               step_q;
  logic               err_q;

  always_comb begin
    slice = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur_ch == SEL_W'(k))
        slice = bus.data_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ch_nxt   = cur_ch;
    cnt_nxt  = count;
    step_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (!bus.mode) begin
      cnt_nxt = '0;
      if ({1'b0, bus.sel} < NCH_V)
        ch_nxt = bus.sel;
      else
        err_nxt = 1'b1;
    end else if (count >= bus.dwell) begin
      // >= so a dwell lowered mid-channel advances at once
      cnt_nxt  = '0;
      ch_nxt   = (cur_ch == LAST) ? '0 : cur_ch + SEL_W'(1);
      step_nxt = 1'b1;
    end else begin
      cnt_nxt = count + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_ch <= '0;
      count  <= '0;
      data_q <= '0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.ena) begin
      cur_ch <= ch_nxt;
      count  <= cnt_nxt;
      data_q <= slice;
      step_q <= step_nxt;
      err_q  <= err_nxt;
    end else begin
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end
  end

  assign bus.data_out = data_q;
  assign bus.ch_out   = cur_ch;
  assign bus.ch_step  = step_q;
  assign bus.sel_err  = err_q;
endmodule

// File: tb/tb_mux_scanner.sv
// Scoreboard bench: directed vectors push expected outputs,
// per-DUT monitors pop and compare after every clock edge.
module tb_mux_scanner;
  typedef struct {
    string      nm;
    logic [1:0] ch;
    logic [1:0] d;
    logic       s;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst4;
  logic rst3;
  int   total = 0;
  int   bad = 0;
  exp_t q4[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  mux_scanner_if #(.N_CH(4), .WIDTH(1), .DWELL_W(8)) b4();
  mux_scanner_if #(.N_CH(3), .WIDTH(2), .DWELL_W(8)) b3();

  mux_scanner #(.N_CH(4), .WIDTH(1), .DWELL_W(8)) u4 (
    .clk(clk), .rst_n(rst4), .bus(b4)
  );
  mux_scanner #(.N_CH(3), .WIDTH(2), .DWELL_W(8)) u3 (
    .clk(clk), .rst_n(rst3), .bus(b3)
  );

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q4.size() > 0) begin
      x = q4.pop_front();
      total++;
      if (b4.ch_out !== x.ch || b4.data_out !== x.d[0] ||
          b4.ch_step !== x.s || b4.sel_err !== x.e) begin
        bad++;
        $display("FAIL n4 %s: got ch=%0d d=%0d s=%0d e=%0d want ch=%0d d=%0d s=%0d e=%0d",
                 x.nm, b4.ch_out, b4.data_out, b4.ch_step, b4.sel_err,
                 x.ch, x.d[0], x.s, x.e);
      end
    end
  end

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q3.size() > 0) begin
      x = q3.pop_front();
      total++;
      if (b3.ch_out !== x.ch || b3.data_out !== x.d ||
          b3.ch_step !== x.s || b3.sel_err !== x.e) begin
        bad++;
        $display("FAIL n3 %s: got ch=%0d d=%0d s=%0d e=%0d want ch=%0d d=%0d s=%0d e=%0d",
                 x.nm, b3.ch_out, b3.data_out, b3.ch_step, b3.sel_err,
                 x.ch, x.d, x.s, x.e);
      end
    end
  end

  task automatic v4(input string nm, input logic r, input logic en,
                    input logic m, input logic [1:0] s,
                    input logic [7:0] dw, input logic [3:0] din,
                    input logic [1:0] ech, input logic ed,
                    input logic es, input logic ee);
    exp_t x;
    @(negedge clk);
    rst4 = r; b4.ena = en; b4.mode = m;
    b4.sel = s; b4.dwell = dw; b4.data_in = din;
    x.nm = nm; x.ch = ech; x.d = {1'b0, ed}; x.s = es; x.e = ee;
    q4.push_back(x);
  endtask

  task automatic v3(input string nm, input logic r, input logic en,
                    input logic m, input logic [1:0] s,
                    input logic [7:0] dw, input logic [1:0] ech,
                    input logic [1:0] ed, input logic es,
                    input logic ee);
    exp_t x;
    @(negedge clk);
    rst3 = r; b3.ena = en; b3.mode = m;
    b3.sel = s; b3.dwell = dw; b3.data_in = 6'b111001;
    x.nm = nm; x.ch = ech; x.d = ed; x.s = es; x.e = ee;
    q3.push_back(x);
  endtask

  initial begin
    logic [3:0] din;
    int c, p;
    rst4 = 1'b0; rst3 = 1'b0;
    b4.ena = 1'b0; b4.mode = 1'b0; b4.sel = '0;
    b4.dwell = '0; b4.data_in = '0;
    b3.ena = 1'b0; b3.mode = 1'b0; b3.sel = '0;
    b3.dwell = '0; b3.data_in = '0;

    // manual select latency
    v4("rst",   0, 1, 0, 2, 0, 4'b0100, 0, 0, 0, 0);
    v4("man1",  1, 1, 0, 2, 0, 4'b0100, 2, 0, 0, 0);
    v4("man2",  1, 1, 0, 2, 0, 4'b0100, 2, 1, 0, 0);

    // scan, dwell=2, din ch1/ch3 high
    din = 4'b1010;
    v4("rst2",  0, 0, 1, 0, 2, din, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      c = (i / 3) % 4;
      p = ((i - 1) / 3) % 4;
      v4("dw2", 1, 1, 1, 3, 2, din, 2'(c), din[p],
         (i % 3) == 0, 0);
    end

    // dwell=0 advances every edge
    v4("dw0a",  1, 1, 1, 0, 0, din, 1, 0, 1, 0);
    v4("dw0b",  1, 1, 1, 0, 0, din, 2, 1, 1, 0);
    v4("dw0c",  1, 1, 1, 0, 0, din, 3, 0, 1, 0);
    v4("dw0w",  1, 1, 1, 0, 0, din, 0, 1, 1, 0);
    v4("dw0e",  1, 1, 1, 0, 0, din, 1, 0, 1, 0);

    // dwell=5 to count 4, then lower to 1
    v4("dw5a",  1, 1, 1, 0, 5, din, 1, 1, 0, 0);
    v4("dw5b",  1, 1, 1, 0, 5, din, 1, 1, 0, 0);
    v4("dw5c",  1, 1, 1, 0, 5, din, 1, 1, 0, 0);
    v4("dw5d",  1, 1, 1, 0, 5, din, 1, 1, 0, 0);
    v4("drop",  1, 1, 1, 0, 1, din, 2, 1, 1, 0);
    v4("hold1", 1, 0, 1, 0, 0, 4'b0000, 2, 1, 0, 0);
    v4("hold2", 1, 0, 0, 1, 0, 4'b0000, 2, 1, 0, 0);
    v4("hold3", 1, 0, 1, 0, 0, 4'b0000, 2, 1, 0, 0);
    v4("rs1",   1, 1, 1, 0, 1, din, 2, 0, 0, 0);
    v4("rs2",   1, 1, 1, 0, 1, din, 3, 0, 1, 0);
    v4("rs3",   1, 1, 1, 0, 1, din, 3, 1, 0, 0);
    v4("rs4",   1, 1, 1, 0, 1, din, 0, 1, 1, 0);
    v4("rs5",   1, 1, 1, 0, 1, din, 0, 0, 0, 0);
    v4("rs6",   1, 1, 1, 0, 1, din, 1, 0, 1, 0);
    v4("rs7",   1, 1, 1, 0, 1, din, 1, 1, 0, 0);
    v4("rs8",   1, 1, 1, 0, 1, din, 2, 1, 1, 0);
    v4("mid",   1, 1, 1, 0, 1, din, 2, 0, 0, 0);

    // reset mid-dwell, restart from ch0 with full dwell
    v4("rstsc", 0, 1, 1, 0, 2, din, 0, 0, 0, 0);
    v4("re1",   1, 1, 1, 0, 2, din, 0, 0, 0, 0);
    v4("re2",   1, 1, 1, 0, 2, din, 0, 0, 0, 0);
    v4("re3",   1, 1, 1, 0, 2, din, 1, 0, 1, 0);

    // scan -> manual -> scan
    v4("s2m",   1, 1, 0, 3, 2, din, 3, 1, 0, 0);
    v4("man0",  1, 1, 0, 0, 2, din, 0, 1, 0, 0);
    v4("m2s1",  1, 1, 1, 3, 1, din, 0, 0, 0, 0);
    v4("m2s2",  1, 1, 1, 3, 1, din, 1, 0, 1, 0);

    // N_CH=3, WIDTH=2: out-of-range select and wrap 2 -> 0
    v3("rst",   0, 1, 0, 2, 0, 0, 2'b00, 0, 0);
    v3("sel2",  1, 1, 0, 2, 0, 2, 2'b01, 0, 0);
    v3("sel3",  1, 1, 0, 3, 0, 2, 2'b11, 0, 1);
    v3("sel1",  1, 1, 0, 1, 0, 1, 2'b11, 0, 0);
    v3("sel1b", 1, 1, 0, 1, 0, 1, 2'b10, 0, 0);
    v3("ena0",  1, 0, 0, 3, 0, 1, 2'b10, 0, 0);
    v3("scan1", 1, 1, 1, 3, 0, 2, 2'b10, 1, 0);
    v3("wrap",  1, 1, 1, 3, 0, 0, 2'b11, 1, 0);

    for (int k = 0; k < 20; k++) begin
      if (q4.size() == 0 && q3.size() == 0) break;
      @(negedge clk);
    end
    if (q4.size() != 0 || q3.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending want 0",
               q4.size(), q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
